regfile_wr_arbiter: RTL

//  Shares the single write port of the processor register bank (enable-gated D

---
 rtl/regfile_wr_arbiter_pkg.sv | 21 ++
 rtl/regfile_wr_arbiter_if.sv | 29 ++
 rtl/regfile_wr_arbiter_rr_pick.sv | 53 +++++
 rtl/regfile_wr_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: default sizes,
// FSM state encoding and the hardwired-zero register address.
package regfile_wr_arbiter_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_AW   = 5;
  localparam int DEF_DW   = 32;

  localparam int REG_ZERO_ADDR = 0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Width of a round-robin pointer able to index n requesters.
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side bundle plus the registered register-bank write port.
interface regfile_wr_arbiter_if
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic               busy;

  modport master (
    output req, req_addr, req_data,
    input  gnt, wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, wr_en, wr_addr, wr_data, busy
  );

endinterface

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate req so ptr sits at bit 0,
// take the lowest set bit, then rotate the winner back.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  localparam int JW = PW + 1;

  logic [NREQ-1:0] rot;
  logic [PW-1:0]   off;
  logic [JW-1:0]   j;
  logic [JW-1:0]   u;

  always_comb begin
    rot   = '0;
    off   = '0;
    valid = 1'b0;
    j     = '0;
    u     = '0;
    idx   = '0;
    gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = JW'(ptr) + JW'(k);
      if (j >= JW'(NREQ)) begin
        j = j - JW'(NREQ);
      end
      rot[k] = req[j[PW-1:0]];
    end
    // Scanning downward leaves the lowest set bit as the final winner.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = PW'(k);
        valid = 1'b1;
      end
    end
    u = JW'(off) + JW'(ptr);
    if (u >= JW'(NREQ)) begin
      u = u - JW'(NREQ);
    end
    idx = u[PW-1:0];
    if (valid) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-bank write-port arbiter: zero-fills every register after reset,
// then grants one writeback source per cycle in round-robin order.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic           clk,
  input  logic           clr,
  regfile_wr_arbiter_if.slave bus
);

  localparam int PW = ptr_width(NREQ);

  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = bus.req_addr[gi*AW +: AW];
    assign data_arr[gi] = bus.req_data[gi*DW +: DW];
  end

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;
  logic            grant_ok;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Grants are suppressed during reset and for the whole init sweep.
  assign grant_ok = (state_q == ST_RUN) && !clr;
  assign bus.gnt  = grant_ok ? pick_gnt : '0;
  assign bus.busy = clr || (state_q == ST_INIT);
  assign sel_addr = addr_arr[pick_idx];
  assign sel_data = data_arr[pick_idx];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_INIT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pick_valid) begin
          // A write to the hardwired-zero register is consumed but never reaches the bank.
          wr_en_d   = (sel_addr != AW'(REG_ZERO_ADDR));
          wr_addr_d = sel_addr;
          wr_data_d = sel_data;
          ptr_d     = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule
